// File: rtl/mp_add_pkg.sv
// Shared types and constants for the multi-precision adder sequencer.
package mp_add_pkg;

    // Controller states: waiting for operands, stepping through bytes, holding a result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mp_state_t;

    // Width of one slice handled by the shared adder
    localparam int BYTE_W = 8;

endpackage

// File: rtl/ripple_carry_adder_8bit.sv
// Shared 8-bit ripple-carry adder built from a chain of full adders.
module ripple_carry_adder_8bit
    import mp_add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W:0] carry;

    assign carry[0] = cin;

    // One full adder per bit; the carry ripples from bit 0 upward
    genvar i;
    generate
        for (i = 0; i < BYTE_W; i++) begin : g_fa
            assign sum[i]     = a[i] ^ b[i] ^ carry[i];
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = carry[BYTE_W];

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision adder controller: one 8-bit adder reused for NUM_BYTES
// cycles, least-significant byte first, with valid/ready on both sides.
// Optional macro MP_ADD_SUBTRACT_EN adds an op_sub input for a-b.
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BYTE_W*NUM_BYTES-1:0]   a,
    input  logic [BYTE_W*NUM_BYTES-1:0]   b,
    input  logic                          cin,
`ifdef MP_ADD_SUBTRACT_EN
    input  logic                          op_sub,
`endif
    output logic                          busy,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [BYTE_W*NUM_BYTES-1:0]   sum,
    output logic                          cout,
    output logic                          ovf
);

    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    mp_state_t state, state_next;

    logic [IDX_W-1:0]                   idx;
    logic                               carry_reg;
    logic [NUM_BYTES-1:0][BYTE_W-1:0]   a_reg;
    logic [NUM_BYTES-1:0][BYTE_W-1:0]   b_reg;
    logic [NUM_BYTES-1:0][BYTE_W-1:0]   sum_reg;
    logic                               cout_reg;
    logic                               ovf_reg;

    logic [BYTE_W-1:0] add_a;
    logic [BYTE_W-1:0] add_b;
    logic [BYTE_W-1:0] add_sum;
    logic              add_cout;
    logic              accept;
    logic              last_byte;
    logic              carry_into_msb;
    logic [BYTE_W*NUM_BYTES-1:0] b_load;
    logic              carry_load;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last_byte = (idx == LAST_IDX);

    assign add_a = a_reg[idx];
    assign add_b = b_reg[idx];

    // Carry into bit 7 of the current slice, recovered from its sum bit
    assign carry_into_msb = add_a[BYTE_W-1] ^ add_b[BYTE_W-1] ^ add_sum[BYTE_W-1];

`ifdef MP_ADD_SUBTRACT_EN
    // Subtraction is a + ~b + 1, so invert b and force the initial carry
    assign b_load     = op_sub ? ~b : b;
    assign carry_load = op_sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    ripple_carry_adder_8bit u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_reg),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept, step through bytes, wait for the consumer
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (last_byte) state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Operand capture, per-byte result write-back and final carry/overflow flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= a;
                        b_reg     <= b_load;
                        carry_reg <= carry_load;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    sum_reg[idx] <= add_sum;
                    carry_reg    <= add_cout;
                    if (last_byte) begin
                        cout_reg <= add_cout;
                        ovf_reg  <= carry_into_msb ^ add_cout;
                        idx      <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed self-checking bench for mp_add_sequencer (NUM_BYTES = 4).
// Define MP_ADD_SUBTRACT_EN for both bench and RTL to exercise subtraction.
module tb_mp_add_sequencer;

    localparam int NB = 4;
    localparam int W  = 8 * NB;
    localparam int MAX_WAIT = 20;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op_sub;
    logic         busy;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_total;
    int n_bad;

    mp_add_sequencer #(.NUM_BYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef MP_ADD_SUBTRACT_EN
        .op_sub    (op_sub),
`endif
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation for a single edge, then scramble the inputs so
    // any late sampling of a/b/cin would corrupt the result
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic ci, input logic sub);
        a        = av;
        b        = bv;
        cin      = ci;
        op_sub   = sub;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h5A5A_A5A5;
        cin      = ~ci;
        op_sub   = ~sub;
    endtask

    // Count edges from the accept edge until res_valid, bounded
    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!res_valid && cycles < MAX_WAIT) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    // Accept the pending result with one res_ready pulse
    task automatic take_result();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({in_ready, busy, res_valid} !== 3'b100) begin
            n_bad++;
            $display("[TB] FAIL reset_flags got=%b want=100", {in_ready, busy, res_valid});
        end
        n_total++;
        if ({sum, cout, ovf} !== {32'h0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL reset_result got sum=%h cout=%b ovf=%b want 0/0/0", sum, cout, ovf);
        end
    endtask

    task automatic test_basic();
        int cyc;
        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        n_total++;
        if ({in_ready, busy} !== 2'b01) begin
            n_bad++;
            $display("[TB] FAIL run_flags got in_ready/busy=%b want=01", {in_ready, busy});
        end
        wait_result(cyc);
        n_total++;
        if (cyc !== 4) begin
            n_bad++;
            $display("[TB] FAIL basic_latency got=%0d want=4", cyc);
        end
        n_total++;
        if ({sum, cout, ovf} !== {32'h0000_0100, 1'b0, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL basic_add got sum=%h cout=%b ovf=%b want 00000100/0/0", sum, cout, ovf);
        end
        take_result();
    endtask

    task automatic test_carry_ripple();
        int cyc;
        start_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        wait_result(cyc);
        n_total++;
        if (cyc !== 4 || {sum, cout, ovf} !== {32'h0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL carry_ripple got cyc=%0d sum=%h cout=%b ovf=%b want 4/00000000/1/0",
                     cyc, sum, cout, ovf);
        end
        take_result();
    endtask

    task automatic test_overflow();
        int cyc;
        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_result(cyc);
        n_total++;
        if (cyc !== 4 || {sum, cout, ovf} !== {32'h8000_0000, 1'b0, 1'b1}) begin
            n_bad++;
            $display("[TB] FAIL ovf_pos got cyc=%0d sum=%h cout=%b ovf=%b want 4/80000000/0/1",
                     cyc, sum, cout, ovf);
        end
        take_result();
        start_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        wait_result(cyc);
        n_total++;
        if (cyc !== 4 || {sum, cout, ovf} !== {32'h0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("[TB] FAIL ovf_neg got cyc=%0d sum=%h cout=%b ovf=%b want 4/00000000/1/1",
                     cyc, sum, cout, ovf);
        end
        take_result();
    endtask

    task automatic test_backpressure();
        int cyc;
        start_op(32'h0102_0304, 32'h1020_3040, 1'b0, 1'b0);
        wait_result(cyc);
        n_total++;
        if (cyc !== 4 || {sum, cout, ovf} !== {32'h1122_3344, 1'b0, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL bp_result got cyc=%0d sum=%h cout=%b ovf=%b want 4/11223344/0/0",
                     cyc, sum, cout, ovf);
        end
        // Offer a new operation while the consumer stalls; it must be ignored
        a        = 32'hFFFF_FFFF;
        b        = 32'hFFFF_FFFF;
        cin      = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_total++;
            if ({res_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, 32'h1122_3344, 1'b0, 1'b0}) begin
                n_bad++;
                $display("[TB] FAIL bp_hold[%0d] got rv=%b ir=%b sum=%h cout=%b ovf=%b want 1/0/11223344/0/0",
                         i, res_valid, in_ready, sum, cout, ovf);
            end
        end
        // in_valid stays high across the result handshake: no same-cycle accept
        take_result();
        n_total++;
        if ({in_ready, busy, res_valid} !== 3'b100) begin
            n_bad++;
            $display("[TB] FAIL bp_release got ir/busy/rv=%b want=100", {in_ready, busy, res_valid});
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({in_ready, busy} !== 2'b10) begin
            n_bad++;
            $display("[TB] FAIL bp_idle got ir/busy=%b want=10", {in_ready, busy});
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        // Two edges after accept: bytes 0 and 1 written, idx == 2
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({in_ready, busy, res_valid, sum, cout, ovf} !== {3'b100, 32'h0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL mid_reset got ir/busy/rv=%b sum=%h cout=%b ovf=%b want 100/00000000/0/0",
                     {in_ready, busy, res_valid}, sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        wait_result(cyc);
        n_total++;
        if (cyc !== 4 || {sum, cout, ovf} !== {32'h2345_6789, 1'b0, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL after_reset got cyc=%0d sum=%h cout=%b ovf=%b want 4/23456789/0/0",
                     cyc, sum, cout, ovf);
        end
        take_result();
    endtask

`ifdef MP_ADD_SUBTRACT_EN
    task automatic test_subtract();
        int cyc;
        start_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        wait_result(cyc);
        n_total++;
        if (cyc !== 4 || {sum, cout, ovf} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL sub_borrow got cyc=%0d sum=%h cout=%b ovf=%b want 4/fffffffe/0/0",
                     cyc, sum, cout, ovf);
        end
        take_result();
        start_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        wait_result(cyc);
        n_total++;
        if (cyc !== 4 || {sum, cout, ovf} !== {32'h7FFF_FFFF, 1'b1, 1'b1}) begin
            n_bad++;
            $display("[TB] FAIL sub_ovf got cyc=%0d sum=%h cout=%b ovf=%b want 4/7fffffff/1/1",
                     cyc, sum, cout, ovf);
        end
        take_result();
    endtask
`endif

    // Scenario sequence and summary
    initial begin
        n_total   = 0;
        n_bad     = 0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op_sub    = 1'b0;
        rst_n     = 1'b1;

        test_reset();
        test_basic();
        test_carry_ripple();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
`ifdef MP_ADD_SUBTRACT_EN
        test_subtract();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
